oram_frontend_responder: RTL
============================

# oram_frontend_responder

Synthesizable stand-in for the ORAM controller's frontend. It implements the responder side of the frontend command/data protocol (Cmd, PAddr, DataIn, DataOut) over a flat on-chip block store with a programmable fixed access latency. Frontend initiators and benches connect to it in place of the full Path ORAM when functional data behaviour is needed and tree/DRAM timing is not.

## Interface
- ORAMB, 512, block size in bits
- ORAMU, 32, program address width
- FEDWidth, 32, frontend data chunk width; FEORAMBChunks = ORAMB/FEDWidth, and ORAMB must be a multiple of FEDWidth
- NumBlocks, 256, number of stored blocks (power of two); IdxWidth = log2(NumBlocks)
- AccessLatency, 16, cycles that model the ORAM access; minimum 2
- Clock  in  1  sole clock, rising edge
- Reset  in  1  synchronous, active-low (0 = reset), sampled on Clock
- Cmd  in  2  0 Update, 1 Append, 2 Read, 3 ReadRmv
- PAddr  in  ORAMU  block address
- CmdValid / CmdReady  in / out  1  command handshake
- DataIn  in  FEDWidth  write chunk
- DataInValid / DataInReady  in / out  1  write-data handshake
- DataOut  out  FEDWidth  read chunk
- DataOutValid / DataOutReady  out / in  1  read-data handshake
- Miss  out  1  one-cycle pulse: Read/ReadRmv of an absent block, or Append of a present block
- AddrError  out  1  one-cycle pulse: PAddr >= NumBlocks
- Busy  out  1  high whenever state != IDLE

## Operation
- Storage: NumBlocks x FEORAMBChunks words of FEDWidth (synchronous RAM, 1-cycle read) plus a NumBlocks-bit Valid register vector.
- Chunk order: the first chunk transferred is the most significant FEDWidth bits of the block, in both directions.
- FSM states: IDLE, WDATA, RLAT, RDATA, WLAT.
- IDLE: CmdReady=1. Acceptance (CmdValid && CmdReady) latches Cmd and PAddr. Update/Append go to WDATA. Read/ReadRmv go to RLAT.
- WDATA: DataInReady=1. Each DataIn handshake writes chunk ChunkCnt into the block and increments ChunkCnt. After chunk FEORAMBChunks-1 is accepted, Valid[idx] is set and the FSM goes to WLAT.
- WLAT: counts AccessLatency cycles, then returns to IDLE.
- Update always allocates; an absent block is legal.
- Append to a present block pulses Miss and still overwrites the block.
- RLAT: counts AccessLatency-1 cycles and prefetches chunk 0, then goes to RDATA.
- RDATA: DataOutValid=1. DataOut holds its value while DataOutReady=0. On each handshake the next chunk is presented in the following cycle with no bubble. After the last handshake, ReadRmv clears Valid[idx] and the FSM returns to IDLE.
- Read of an absent block: Miss pulses and all chunks return 0. ReadRmv of an absent block behaves the same way.
- AddrError (PAddr >= NumBlocks): pulse AddrError.
  - Writes: the full chunk stream is still consumed and discarded, and no state changes.
  - Reads: zeros are returned and Miss is not pulsed.
- Miss and AddrError pulse in the cycle after acceptance.
- Reset (Reset=0) has priority over everything, including a transfer in progress:
  - FSM goes to IDLE and counters clear.
  - All Valid bits clear; RAM contents are untouched.
  - CmdReady=0, DataInReady=0, DataOutValid=0, DataOut=0, Miss=0, AddrError=0, Busy=0 while Reset=0.
  - CmdReady=1 in the first cycle after Reset returns high.

## Timing
- Command accepted at edge T.
- Write path:
  - DataInReady=1 from cycle T+1.
  - Last chunk accepted at edge W; Valid is set at W.
  - CmdReady=1 again in cycle W+AccessLatency+1.
  - Back-to-back chunks are accepted one per cycle.
- Read path:
  - DataOutValid first high in cycle T+AccessLatency.
  - With DataOutReady held at 1, the last chunk is transferred in cycle T+AccessLatency+FEORAMBChunks-1.
  - CmdReady=1 in the following cycle.
- Only one command is outstanding at a time; CmdReady=0 in every non-IDLE state.
- DataInReady and DataOutValid are never both high.
- ChunkCnt width is log2(FEORAMBChunks)+1 bits and does not wrap within a block. The latency counter saturates at its terminal count.
- Read-after-write to the same address returns the new data.

## Test plan
- Update addr 5 with chunks 0x0..0xF (16 chunks, 512-bit block), then Read addr 5 with DataOutReady=1. Required:
  - DataOutValid rises exactly 16 cycles after acceptance.
  - Chunks 0x0..0xF arrive in order, one per cycle.
  - Miss never pulses.
- Read addr 7 on a never-written address → Miss pulses at T+1 and 16 zero chunks are returned.
- ReadRmv addr 5, then Read addr 5 → the first returns the stored data; the second pulses Miss and returns zeros.
- Append addr 5 twice → the second Append pulses Miss and its data is stored; a following Read returns the second data.
- Read with DataOutReady toggling every other cycle → each chunk is held stable until its handshake, and exactly 16 handshakes occur.
- Error and reset cases:
  - PAddr=256 Update: AddrError pulses and 16 chunks are consumed.
  - Reset=0 for 1 cycle mid-WDATA: next cycle is IDLE with all outputs at reset values, and a Read of a previously valid address pulses Miss.

Source files
------------

// File: rtl/oram_frontend_responder_if.sv
// Frontend command/data bundle between an ORAM initiator (master) and the
// block-store responder (slave).
interface oram_frontend_responder_if #(
   parameter int ORAMU    = 32,
   parameter int FEDWidth = 32
);
   logic [1:0]          cmd;
   logic [ORAMU-1:0]    paddr;
   logic                cmd_valid;
   logic                cmd_ready;
   logic [FEDWidth-1:0] data_in;
   logic                data_in_valid;
   logic                data_in_ready;
   logic [FEDWidth-1:0] data_out;
   logic                data_out_valid;
   logic                data_out_ready;
   logic                miss;
   logic                addr_error;
   logic                busy;

   modport master (
      output cmd, paddr, cmd_valid, data_in, data_in_valid, data_out_ready,
      input  cmd_ready, data_in_ready, data_out, data_out_valid, miss, addr_error, busy
   );

   modport slave (
      input  cmd, paddr, cmd_valid, data_in, data_in_valid, data_out_ready,
      output cmd_ready, data_in_ready, data_out, data_out_valid, miss, addr_error, busy
   );
endinterface

// File: rtl/oram_frontend_responder.sv
// Flat on-chip block store answering the ORAM frontend protocol with a fixed,
// programmable access latency in place of the real Path ORAM.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// WDATA | accepting write chunks into the addressed block
// WLAT  | modelled write access latency
// RLAT  | modelled read access latency, prefetching chunk 0
// RDATA | streaming read chunks out
module oram_frontend_responder #(
   parameter int ORAMB         = 512,
   parameter int ORAMU         = 32,
   parameter int FEDWidth      = 32,
   parameter int NumBlocks     = 256,
   parameter int AccessLatency = 16
) (
   input logic clk_sys_i,
   input logic rst_b_i,
   oram_frontend_responder_if.slave fe
);
   localparam int Chunks   = ORAMB / FEDWidth;
   localparam int ChunkW   = $clog2(Chunks);
   localparam int CntW     = ChunkW + 1;
   localparam int IdxWidth = $clog2(NumBlocks);
   localparam int LatW     = $clog2(AccessLatency);
   localparam int DepthW   = IdxWidth + ChunkW;

   localparam logic [1:0] CMD_APPEND   = 2'd1;
   localparam logic [1:0] CMD_READ_RMV = 2'd3;

   typedef enum logic [2:0] {IDLE, WDATA, WLAT, RLAT, RDATA} state_e;

   state_e                state_q, state_d;
   logic [IdxWidth-1:0]   idx_q, idx_d;
   logic                  err_q, err_d;
   logic                  rmv_q, rmv_d;
   logic                  zero_q, zero_d;
   logic [CntW-1:0]       chunk_cnt_q, chunk_cnt_d;
   logic [LatW-1:0]       lat_cnt_q, lat_cnt_d;
   logic [NumBlocks-1:0]  valid_q, valid_d;
   logic                  miss_q, miss_d;
   logic                  addr_error_q, addr_error_d;

   logic                  cmd_ready_c, din_ready_c, dout_valid_c, ram_we_c;
   logic [ChunkW-1:0]     rd_chunk_c;
   logic [IdxWidth-1:0]   acc_idx_c;
   logic                  acc_err_c, acc_hit_c;

   logic [FEDWidth-1:0]   mem [2**DepthW];
   logic [FEDWidth-1:0]   ram_rd_q;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      err_d        = err_q;
      rmv_d        = rmv_q;
      zero_d       = zero_q;
      chunk_cnt_d  = chunk_cnt_q;
      lat_cnt_d    = lat_cnt_q;
      valid_d      = valid_q;
      miss_d       = 1'b0;
      addr_error_d = 1'b0;
      cmd_ready_c  = 1'b0;
      din_ready_c  = 1'b0;
      dout_valid_c = 1'b0;
      ram_we_c     = 1'b0;
      rd_chunk_c   = chunk_cnt_q[ChunkW-1:0];
      acc_idx_c    = fe.paddr[IdxWidth-1:0];
      acc_err_c    = |fe.paddr[ORAMU-1:IdxWidth];
      acc_hit_c    = valid_q[acc_idx_c];

      unique case (state_q)
         IDLE: begin
            cmd_ready_c = 1'b1;
            if (fe.cmd_valid) begin
               idx_d        = acc_idx_c;
               err_d        = acc_err_c;
               rmv_d        = (fe.cmd == CMD_READ_RMV);
               zero_d       = acc_err_c || !acc_hit_c;
               chunk_cnt_d  = '0;
               addr_error_d = acc_err_c;
               if (!fe.cmd[1]) begin
                  miss_d  = (fe.cmd == CMD_APPEND) && acc_hit_c && !acc_err_c;
                  state_d = WDATA;
               end else begin
                  miss_d    = !acc_hit_c && !acc_err_c;
                  lat_cnt_d = LatW'(AccessLatency - 2);
                  state_d   = RLAT;
               end
            end
         end
         WDATA: begin
            din_ready_c = 1'b1;
            if (fe.data_in_valid) begin
               ram_we_c    = !err_q;
               chunk_cnt_d = chunk_cnt_q + CntW'(1);
               if (chunk_cnt_q == CntW'(Chunks - 1)) begin
                  if (!err_q) valid_d[idx_q] = 1'b1;
                  lat_cnt_d = LatW'(AccessLatency - 1);
                  state_d   = WLAT;
               end
            end
         end
         WLAT: begin
            if (lat_cnt_q == '0) state_d = IDLE;
            else                 lat_cnt_d = lat_cnt_q - LatW'(1);
         end
         RLAT: begin
            if (lat_cnt_q == '0) state_d = RDATA;
            else                 lat_cnt_d = lat_cnt_q - LatW'(1);
         end
         RDATA: begin
            dout_valid_c = 1'b1;
            // Read address runs one chunk ahead on a handshake so the next
            // chunk appears without a bubble; otherwise it re-reads and holds.
            if (fe.data_out_ready) begin
               chunk_cnt_d = chunk_cnt_q + CntW'(1);
               rd_chunk_c  = chunk_cnt_q[ChunkW-1:0] + ChunkW'(1);
               if (chunk_cnt_q == CntW'(Chunks - 1)) begin
                  if (rmv_q && !err_q) valid_d[idx_q] = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys_i) begin
      if (!rst_b_i) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         err_q        <= 1'b0;
         rmv_q        <= 1'b0;
         zero_q       <= 1'b0;
         chunk_cnt_q  <= '0;
         lat_cnt_q    <= '0;
         valid_q      <= '0;
         miss_q       <= 1'b0;
         addr_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         err_q        <= err_d;
         rmv_q        <= rmv_d;
         zero_q       <= zero_d;
         chunk_cnt_q  <= chunk_cnt_d;
         lat_cnt_q    <= lat_cnt_d;
         valid_q      <= valid_d;
         miss_q       <= miss_d;
         addr_error_q <= addr_error_d;
      end
   end

   // Block store keeps its contents across reset; only the Valid vector clears.
   always_ff @(posedge clk_sys_i) begin
      if (ram_we_c && rst_b_i) mem[{idx_q, chunk_cnt_q[ChunkW-1:0]}] <= fe.data_in;
      ram_rd_q <= mem[{idx_q, rd_chunk_c}];
   end

   assign fe.cmd_ready      = rst_b_i && cmd_ready_c;
   assign fe.data_in_ready  = rst_b_i && din_ready_c;
   assign fe.data_out_valid = rst_b_i && dout_valid_c;
   assign fe.data_out       = (rst_b_i && dout_valid_c && !zero_q) ? ram_rd_q : '0;
   assign fe.miss           = rst_b_i && miss_q;
   assign fe.addr_error     = rst_b_i && addr_error_q;
   assign fe.busy           = rst_b_i && (state_q != IDLE);
endmodule
